// File: rtl/pc_pkg.sv
// Shared encodings for the PC sequencer: next-PC select, sequencer state and the reset vector.
// Pure declarations; no logic, no latency, no flow control.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_JR     = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_DELAY   = 2'b01,
    ST_HALTED  = 2'b10
  } state_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-control bundle between the decode/commit logic (master) and the PC sequencer (slave).
// No logic; advance=0 is the stall that holds all sequencer state.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  import pc_pkg::*;

  logic              advance;
  pc_sel_e           pc_sel;
  logic              is_true;
  logic [ADDR_W-1:0] extended_imm;
  logic [25:0]       j_addr;
  logic [ADDR_W-1:0] reg_data_a;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] link_pc;
  logic              in_delay_slot;
  logic              active;

  modport master (
    output advance, pc_sel, is_true, extended_imm, j_addr, reg_data_a,
    input  pc, link_pc, in_delay_slot, active
  );

  modport slave (
    input  advance, pc_sel, is_true, extended_imm, j_addr, reg_data_a,
    output pc, link_pc, in_delay_slot, active
  );

endinterface

// File: rtl/pc_target.sv
// Combinational next-PC arithmetic: pc+4 plus the branch, jump and register transfer targets.
// Zero latency; no state, so no backpressure.
module pc_target
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  pc_sel_e           i_pc_sel,
  input  logic [ADDR_W-1:0] i_extended_imm,
  input  logic [25:0]       i_j_addr,
  input  logic [ADDR_W-1:0] i_reg_data_a,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic [ADDR_W-1:0] o_target
);

  // Jumps keep the region bits above bit 27 of the delay-slot address.
  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);

  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_branch;
  logic [ADDR_W-1:0] w_jump;

  assign w_pc_plus4 = i_pc + ADDR_W'(4);
  assign w_branch   = w_pc_plus4 + (i_extended_imm << 2);
  assign w_jump     = (w_pc_plus4 & ~LOW28_MASK) | ADDR_W'({i_j_addr, 2'b00});

  assign o_pc_plus4 = w_pc_plus4;

  always_comb begin
    o_target = w_pc_plus4;
    case (i_pc_sel)
      SEL_BRANCH: o_target = w_branch;
      SEL_JUMP:   o_target = w_jump;
      SEL_JR:     o_target = i_reg_data_a;
      default:    o_target = w_pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// MIPS-style PC sequencer with one architectural delay slot and halt-on-target detection.
// Outputs update one cycle after an advancing edge; advance=0 holds pc, state and latched target.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] HALT_ADDR    = '0
) (
  input logic          clk,
  input logic          rst_n,
  pc_sequencer_if.slave bus
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_target;
  logic              r_in_delay;
  logic              r_active;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_target;
  logic              w_taken;

  pc_target #(
    .ADDR_W (ADDR_W)
  ) u_pc_target (
    .i_pc           (r_pc),
    .i_pc_sel       (bus.pc_sel),
    .i_extended_imm (bus.extended_imm),
    .i_j_addr       (bus.j_addr),
    .i_reg_data_a   (bus.reg_data_a),
    .o_pc_plus4     (w_pc_plus4),
    .o_target       (w_target)
  );

  assign w_taken = ((bus.pc_sel == SEL_BRANCH) && bus.is_true) ||
                   (bus.pc_sel == SEL_JUMP) ||
                   (bus.pc_sel == SEL_JR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_VECTOR;
      r_target   <= '0;
      r_in_delay <= 1'b0;
      r_active   <= 1'b1;
    end else if (bus.advance) begin
      case (r_state)
        ST_RUN: begin
          r_pc <= w_pc_plus4;
          if (w_taken) begin
            r_target   <= w_target;
            r_state    <= ST_DELAY;
            r_in_delay <= 1'b1;
          end
        end
        // A transfer decoded in the delay slot is deliberately dropped.
        ST_DELAY: begin
          r_in_delay <= 1'b0;
          if (r_target == HALT_ADDR) begin
            r_state  <= ST_HALTED;
            r_active <= 1'b0;
          end else begin
            r_pc    <= r_target;
            r_state <= ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pc            = r_pc;
  assign bus.link_pc       = r_pc + ADDR_W'(8);
  assign bus.in_delay_slot = r_in_delay;
  assign bus.active        = r_active;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed spot checks plus randomized advance/select traffic against a queue-based PC model.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam logic [31:0] RV   = 32'hBFC0_0000;
  localparam logic [31:0] HALT = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pc_sequencer_if #(.ADDR_W(32)) bus();

  pc_sequencer #(
    .ADDR_W       (32),
    .RESET_VECTOR (RV),
    .HALT_ADDR    (HALT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending transfer is a one-entry queue; its presence means "in delay slot".
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  bit          m_halted;

  function automatic void model_reset();
    m_pc = RV;
    m_pend.delete();
    m_halted = 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] seq;
    logic [31:0] tgt;
    if (!rst_n) begin
      model_reset();
    end else if (bus.advance && !m_halted) begin
      if (m_pend.size() != 0) begin
        tgt = m_pend.pop_front();
        if (tgt == HALT) m_halted = 1'b1;
        else             m_pc = tgt;
      end else begin
        seq = m_pc + 32'd4;
        case (bus.pc_sel)
          SEL_BRANCH: if (bus.is_true) m_pend.push_back(seq + bus.extended_imm * 32'd4);
          SEL_JUMP:   m_pend.push_back({seq[31:28], bus.j_addr, 2'b00});
          SEL_JR:     m_pend.push_back(bus.reg_data_a);
          default:    ;
        endcase
        m_pc = seq;
      end
    end
  end

  always @(negedge clk) begin
    check("pc", bus.pc, m_pc);
    check("link_pc", bus.link_pc, m_pc + 32'd8);
    check("in_delay_slot", {31'b0, bus.in_delay_slot}, {31'b0, (m_pend.size() != 0)});
    check("active", {31'b0, bus.active}, {31'b0, !m_halted});
  end

  task automatic lit(input string n, input logic [31:0] p, input bit ids, input bit act);
    check({n, ".pc"}, bus.pc, p);
    check({n, ".link_pc"}, bus.link_pc, p + 32'd8);
    check({n, ".in_delay_slot"}, {31'b0, bus.in_delay_slot}, {31'b0, ids});
    check({n, ".active"}, {31'b0, bus.active}, {31'b0, act});
  endtask

  task automatic cyc(input bit adv, input logic [1:0] sel, input bit tr,
                     input logic [31:0] imm, input logic [25:0] ja, input logic [31:0] rda);
    bus.advance      = adv;
    bus.pc_sel       = pc_sel_e'(sel);
    bus.is_true      = tr;
    bus.extended_imm = imm;
    bus.j_addr       = ja;
    bus.reg_data_a   = rda;
    @(negedge clk);
    bus.advance = 1'b0;
  endtask

  task automatic seq_step();
    cyc(1'b1, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
  endtask

  task automatic do_reset(input string n);
    bus.advance = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 lit({n, ".async"}, RV, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] r16;
    model_reset();
    bus.advance      = 1'b0;
    bus.pc_sel       = SEL_SEQ;
    bus.is_true      = 1'b0;
    bus.extended_imm = '0;
    bus.j_addr       = '0;
    bus.reg_data_a   = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    lit("reset", 32'hBFC0_0000, 1'b0, 1'b1);
    seq_step(); lit("seq1", 32'hBFC0_0004, 1'b0, 1'b1);
    seq_step(); lit("seq2", 32'hBFC0_0008, 1'b0, 1'b1);
    seq_step(); lit("seq3", 32'hBFC0_000C, 1'b0, 1'b1);

    do_reset("r_br_t");
    cyc(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'hBFC3_2000);
    seq_step(); lit("br_t.start", 32'hBFC3_2000, 1'b0, 1'b1);
    cyc(1'b1, 2'b01, 1'b1, 32'h0000_0010, 26'h0, 32'h0);
    lit("br_t.slot", 32'hBFC3_2004, 1'b1, 1'b1);
    seq_step(); lit("br_t.tgt", 32'hBFC3_2044, 1'b0, 1'b1);

    do_reset("r_br_nt");
    cyc(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'hBFC3_2000);
    seq_step();
    cyc(1'b1, 2'b01, 1'b0, 32'h0000_0010, 26'h0, 32'h0);
    lit("br_nt.next", 32'hBFC3_2004, 1'b0, 1'b1);
    seq_step(); lit("br_nt.seq", 32'hBFC3_2008, 1'b0, 1'b1);

    do_reset("r_j");
    repeat (4) seq_step();
    lit("j.start", 32'hBFC0_0010, 1'b0, 1'b1);
    cyc(1'b1, 2'b10, 1'b0, 32'h0, 26'h032_5039, 32'h0);
    lit("j.slot", 32'hBFC0_0014, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b01, 1'b1, 32'h10, 26'h0, 32'h0);
      lit("j.stall", 32'hBFC0_0014, 1'b1, 1'b1);
    end
    cyc(1'b1, 2'b01, 1'b1, 32'h0000_0100, 26'h0, 32'h0);
    lit("j.tgt", 32'hB0C9_40E4, 1'b0, 1'b1);
    seq_step(); lit("j.after", 32'hB0C9_40E8, 1'b0, 1'b1);

    do_reset("r_halt");
    cyc(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h0);
    lit("halt.slot", 32'hBFC0_0004, 1'b1, 1'b1);
    seq_step(); lit("halt.stop", 32'hBFC0_0004, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 32'h0, 26'h3FF_FFFF, 32'h0);
    cyc(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h1234_5678);
    seq_step(); lit("halt.hold", 32'hBFC0_0004, 1'b0, 1'b0);

    do_reset("r_mid");
    cyc(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h1234_5678);
    lit("mid.slot", 32'hBFC0_0004, 1'b1, 1'b1);
    do_reset("mid_rst");
    seq_step(); lit("mid.after", 32'hBFC0_0004, 1'b0, 1'b1);

    do_reset("r_wrap");
    cyc(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'hFFFF_FFFC);
    seq_step(); lit("wrap.top", 32'hFFFF_FFFC, 1'b0, 1'b1);
    seq_step(); lit("wrap.zero", 32'h0000_0000, 1'b0, 1'b1);
    cyc(1'b1, 2'b01, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0);
    seq_step(); lit("wrap.back", 32'hFFFF_FFFC, 1'b0, 1'b1);

    do_reset("r_mis");
    cyc(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'hBFC0_0123);
    seq_step(); lit("jr.misaligned", 32'hBFC0_0123, 1'b0, 1'b1);

    do_reset("r_rand");
    for (int i = 0; i < 3000; i++) begin
      if ((m_halted && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 199) == 0)) begin
        do_reset("rand_rst");
      end
      r16 = 16'($urandom);
      cyc(($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
          {{16{r16[15]}}, r16}, 26'($urandom),
          ($urandom_range(0, 19) == 0) ? 32'h0 : $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
